// File: rtl/corr_score_pkg.sv
// Shared types and constants for the template-correlation scorer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package corr_score_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_SIM = 1'b0;
  localparam logic MODE_SAD = 1'b1;

  // Largest value a w-bit unsigned pixel can hold.
  function automatic logic [31:0] pix_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/corr_term.sv
// Per-pixel correlation term: |sram - search|, or its complement for similarity.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the result with its own valid.
// Ports: sram_pix/search_pix = pixel pair, mode = MODE_SIM/MODE_SAD, term = result.
module corr_term
  import corr_score_pkg::*;
#(
  parameter int PIX_W = 10
) (
  input  logic [PIX_W-1:0] sram_pix,
  input  logic [PIX_W-1:0] search_pix,
  input  logic             mode,
  output logic [PIX_W-1:0] term
);

  localparam logic [31:0]      MAX_FULL = pix_max(PIX_W);
  localparam logic [PIX_W-1:0] MAX_PIX  = MAX_FULL[PIX_W-1:0];

  logic [PIX_W-1:0] diff;

  // Subtract the smaller from the larger so the difference never wraps.
  always_comb begin
    diff = '0;
    term = '0;
    if (sram_pix >= search_pix) diff = sram_pix - search_pix;
    else                        diff = search_pix - sram_pix;
    term = (mode == MODE_SAD) ? diff : (MAX_PIX - diff);
  end

endmodule

// File: rtl/corr_score_engine.sv
// Template-vs-window correlation scorer (similarity or SAD) with start/done handshake.
// Latency: start accepted at edge 0 -> oDone in cycle TMPL_W*TMPL_H + RD_LAT + 1.
// Backpressure: none; reads are issued every cycle, starts outside IDLE are dropped.
// Ports: iCLK/iRST_N clock and async reset; iStart/iMode/iXstart/iYstart run request;
//        reading_* read data; oX/oY_* addresses with oRdEn; oBusy/oDone/oSat/oScore status.
module corr_score_engine
  import corr_score_pkg::*;
#(
  parameter int PIX_W   = 10,
  parameter int COORD_W = 13,
  parameter int TMPL_W  = 32,
  parameter int TMPL_H  = 32,
  parameter int RD_LAT  = 2,
  parameter int SCORE_W = 32
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iStart,
  input  logic               iMode,
  input  logic [COORD_W-1:0] iXstart,
  input  logic [COORD_W-1:0] iYstart,
  input  logic [PIX_W-1:0]   reading_sram,
  input  logic [PIX_W-1:0]   reading_search,
  output logic [COORD_W-1:0] oX_sram,
  output logic [COORD_W-1:0] oY_sram,
  output logic [COORD_W-1:0] oX_search,
  output logic [COORD_W-1:0] oY_search,
  output logic               oRdEn,
  output logic               oBusy,
  output logic               oDone,
  output logic               oSat,
  output logic [SCORE_W-1:0] oScore
);

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(TMPL_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(TMPL_H - 1);
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

  state_t               state, state_nxt;
  logic [COORD_W-1:0]   x_cnt, y_cnt, x_org, y_org;
  logic                 mode_q;
  logic [RD_LAT-1:0]    vld_pipe, vld_nxt;
  logic [SCORE_W-1:0]   acc, acc_nxt, score;
  logic                 sat_acc, sat_nxt, sat_out;
  logic [PIX_W-1:0]     term;
  logic [SCORE_W:0]     sum;
  logic                 rd_en, start_ok, scan_end;

  assign start_ok = (state == IDLE) && iStart;
  assign scan_end = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  corr_term #(.PIX_W(PIX_W)) u_term (
    .sram_pix   (reading_sram),
    .search_pix (reading_search),
    .mode       (mode_q),
    .term       (term)
  );

  // Next state and per-state outputs.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart) state_nxt = ISSUE;
      end
      ISSUE: begin
        rd_en = 1'b1;
        oBusy = 1'b1;
        if (scan_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        oBusy = 1'b1;
        // Leave once the read in flight now is the last one.
        if (vld_nxt == '0) state_nxt = DONE;
      end
      DONE: begin
        oDone     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_nxt;
  end

  // Run parameters and raster-scan counters; counters end a run back at 0.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      x_org  <= '0;
      y_org  <= '0;
      mode_q <= MODE_SIM;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else begin
      if (start_ok) begin
        x_org  <= iXstart;
        y_org  <= iYstart;
        mode_q <= iMode;
      end
      if (rd_en) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : (y_cnt + COORD_ONE);
        end else begin
          x_cnt <= x_cnt + COORD_ONE;
        end
      end
    end
  end

  // Read-valid pipeline: the top bit marks the cycle the matching data arrives.
  assign vld_nxt = (vld_pipe << 1) | RD_LAT'(rd_en);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) vld_pipe <= '0;
    else         vld_pipe <= vld_nxt;
  end

  // Saturating accumulate with a sticky overflow flag.
  always_comb begin
    sum     = {1'b0, acc} + (SCORE_W+1)'(term);
    acc_nxt = acc;
    sat_nxt = sat_acc;
    if (vld_pipe[RD_LAT-1]) begin
      if (sum[SCORE_W]) begin
        acc_nxt = '1;
        sat_nxt = 1'b1;
      end else begin
        acc_nxt = sum[SCORE_W-1:0];
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      acc     <= '0;
      sat_acc <= 1'b0;
      score   <= '0;
      sat_out <= 1'b0;
    end else begin
      if (start_ok) begin
        acc     <= '0;
        sat_acc <= 1'b0;
      end else begin
        acc     <= acc_nxt;
        sat_acc <= sat_nxt;
      end
      // Capture including the final term so oScore is valid alongside oDone.
      if ((state == DRAIN) && (state_nxt == DONE)) begin
        score   <= acc_nxt;
        sat_out <= sat_nxt;
      end
    end
  end

  assign oX_sram   = x_org + x_cnt;
  assign oY_sram   = y_org + y_cnt;
  assign oX_search = x_cnt;
  assign oY_search = y_cnt;
  assign oRdEn     = rd_en;
  assign oScore    = score;
  assign oSat      = sat_out;

endmodule

// File: tb/tb_corr_score_engine.sv
// Directed bench for corr_score_engine: 4x4 template, RD_LAT=2, plus a 12-bit-score twin.
// Latency: expects oDone in cycle 19 after a start accepted at edge 0.
// Backpressure: none; results go through a scoreboard queue popped on oDone.
module tb_corr_score_engine;

  localparam int PIX_W   = 10;
  localparam int COORD_W = 13;
  localparam int TW      = 4;
  localparam int TH      = 4;
  localparam int RD_LAT  = 2;
  localparam int N       = TW * TH;
  localparam int LAT     = N + RD_LAT + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic [COORD_W-1:0] xs = '0, ys = '0;
  logic [PIX_W-1:0]   rd_sram, rd_search;

  logic [COORD_W-1:0] xa_sram, ya_sram, xa_srch, ya_srch;
  logic               rden_a, busy_a, done_a, sat_a;
  logic [31:0]        score_a;
  logic [COORD_W-1:0] xb_sram, yb_sram, xb_srch, yb_srch;
  logic               rden_b, busy_b, done_b, sat_b;
  logic [11:0]        score_b;

  corr_score_engine #(.PIX_W(PIX_W), .COORD_W(COORD_W), .TMPL_W(TW), .TMPL_H(TH),
                      .RD_LAT(RD_LAT), .SCORE_W(32)) dut_a (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iMode(mode), .iXstart(xs), .iYstart(ys),
    .reading_sram(rd_sram), .reading_search(rd_search),
    .oX_sram(xa_sram), .oY_sram(ya_sram), .oX_search(xa_srch), .oY_search(ya_srch),
    .oRdEn(rden_a), .oBusy(busy_a), .oDone(done_a), .oSat(sat_a), .oScore(score_a));

  corr_score_engine #(.PIX_W(PIX_W), .COORD_W(COORD_W), .TMPL_W(TW), .TMPL_H(TH),
                      .RD_LAT(RD_LAT), .SCORE_W(12)) dut_b (
    .iCLK(clk), .iRST_N(rst_n), .iStart(start), .iMode(mode), .iXstart(xs), .iYstart(ys),
    .reading_sram(rd_sram), .reading_search(rd_search),
    .oX_sram(xb_sram), .oY_sram(yb_sram), .oX_search(xb_srch), .oY_search(yb_srch),
    .oRdEn(rden_b), .oBusy(busy_b), .oDone(done_b), .oSat(sat_b), .oScore(score_b));

  always #10 clk = ~clk;

  int checks = 0, errors = 0, done_cnt = 0, rden_cnt = 0;

  // Pixel sources: constants, or an address-dependent pattern.
  int             pat = 0;
  logic [PIX_W-1:0] s_const = 10'd500, t_const = 10'd500;

  function automatic logic [PIX_W-1:0] f_sram(int x, int y);
    if (pat == 0) return s_const;
    return 10'((x * 37 + y * 11 + 3) % 1024);
  endfunction

  function automatic logic [PIX_W-1:0] f_search(int x, int y);
    if (pat == 0) return t_const;
    return 10'((x * 5 + y * 97 + 200) % 1024);
  endfunction

  // Memories with RD_LAT registered stages.
  logic [PIX_W-1:0] sram_p [RD_LAT] = '{default: '0};
  logic [PIX_W-1:0] srch_p [RD_LAT] = '{default: '0};
  always @(posedge clk) begin
    sram_p[0] <= f_sram(int'(xa_sram), int'(ya_sram));
    srch_p[0] <= f_search(int'(xa_srch), int'(ya_srch));
    for (int i = 1; i < RD_LAT; i++) begin
      sram_p[i] <= sram_p[i-1];
      srch_p[i] <= srch_p[i-1];
    end
  end
  assign rd_sram   = sram_p[RD_LAT-1];
  assign rd_search = srch_p[RD_LAT-1];

  typedef struct { logic [31:0] sa; logic sat_a; logic [11:0] sb; logic sat_b; } exp_t;
  typedef struct { logic [COORD_W-1:0] xs, ys, xt, yt; } addr_t;
  exp_t  sb_q[$];
  addr_t addr_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(int ox, int oy, logic m);
    exp_t   e;
    longint sum = 0;
    for (int ty = 0; ty < TH; ty++)
      for (int tx = 0; tx < TW; tx++) begin
        int s = int'(f_sram((ox + tx) % 8192, (oy + ty) % 8192));
        int t = int'(f_search(tx, ty));
        int d = (s > t) ? s - t : t - s;
        sum += m ? d : (1023 - d);
      end
    e.sa    = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sum);
    e.sat_a = (sum > 64'hFFFF_FFFF);
    e.sb    = (sum > 4095) ? 12'hFFF : 12'(sum);
    e.sat_b = (sum > 4095);
    return e;
  endfunction

  // Address and result monitors.
  always @(negedge clk) begin
    if (rst_n && rden_a) begin
      addr_t a;
      rden_cnt++;
      checks++;
      assert (addr_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_rden: observed unexpected read at (%0d,%0d) expected none", xa_sram, ya_sram);
      end
      if (addr_q.size() != 0) begin
        a = addr_q.pop_front();
        check("x_sram", xa_sram, a.xs);
        check("y_sram", ya_sram, a.ys);
        check("x_search", xa_srch, a.xt);
        check("y_search", ya_srch, a.yt);
      end
    end
    if (done_a) begin
      exp_t e;
      done_cnt++;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done: observed oDone=1 expected no pending run");
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("score_a", score_a, e.sa);
        check("sat_a", sat_a, e.sat_a);
        check("done_b", done_b, 1);
        check("score_b", score_b, e.sb);
        check("sat_b", sat_b, e.sat_b);
        check("busy_at_done", busy_a, 0);
      end
    end
  end

  // Call at a negedge in IDLE; returns at the negedge of cycle 1.
  task automatic start_run(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y, input logic m);
    addr_t a;
    xs = x; ys = y; mode = m; start = 1'b1;
    sb_q.push_back(model(int'(x), int'(y), m));
    for (int ty = 0; ty < TH; ty++)
      for (int tx = 0; tx < TW; tx++) begin
        a.xs = 13'(int'(x) + tx); a.ys = 13'(int'(y) + ty);
        a.xt = 13'(tx);           a.yt = 13'(ty);
        addr_q.push_back(a);
      end
    rden_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    xs = ~x; ys = x ^ y; mode = ~m;   // must not affect the run in flight
    check("busy_cycle1", busy_a, 1);
  endtask

  // Waits for oDone starting from cycle 'from'; checks latency and read count.
  task automatic wait_done(input string tag, input int from);
    int cyc = from;
    while (!done_a && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, LAT);
    check({tag, "_rden_cnt"}, rden_cnt, N);
    check({tag, "_addr_left"}, addr_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x_sram"}, xa_sram, 0);
    check({tag, "_y_sram"}, ya_sram, 0);
    check({tag, "_x_search"}, xa_srch, 0);
    check({tag, "_y_search"}, ya_srch, 0);
    check({tag, "_rden"}, rden_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_sat"}, sat_a, 0);
    check({tag, "_score"}, score_a, 0);
    check({tag, "_score_b"}, score_b, 0);
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Identical pixels, similarity: 16*1023; 12-bit twin saturates.
    start_run(13'd0, 13'd0, 1'b0);
    wait_done("t1", 1);
    repeat (5) @(negedge clk);
    check("t1_score_hold", score_a, 16368);
    check("t1_sat_b_hold", sat_b, 1);

    // Constant difference of 5: SAD then similarity.
    s_const = 10'd300; t_const = 10'd305;
    start_run(13'd0, 13'd0, 1'b1);
    wait_done("t2sad", 1);
    @(negedge clk);
    start_run(13'd0, 13'd0, 1'b0);
    wait_done("t2sim", 1);
    @(negedge clk);

    // Origin and scan order with patterned data, then origin wrap.
    pat = 1;
    start_run(13'd100, 13'd7, 1'b0);
    wait_done("t3", 1);
    @(negedge clk);
    start_run(13'd8190, 13'd8191, 1'b1);
    wait_done("t3wrap", 1);
    @(negedge clk);

    // Start while busy is ignored; start right after oDone is accepted.
    dc = done_cnt;
    start_run(13'd20, 13'd30, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; xs = 13'd9; ys = 13'd9; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4", 6);
    @(negedge clk);
    start_run(13'd5, 13'd6, 1'b0);
    wait_done("t4b2b", 1);
    repeat (4) @(negedge clk);
    check("t4_done_count", done_cnt - dc, 2);

    // Mid-run reset aborts; a fresh run afterwards scores correctly.
    start_run(13'd50, 13'd60, 1'b0);
    repeat (7) @(negedge clk);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    sb_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_no_done", done_cnt - dc, 0);
    start_run(13'd50, 13'd60, 1'b0);
    wait_done("t6", 1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/corr_score_engine.md
Name: corr_score_engine

Overview:
- Parametrised template-correlation scorer for the camera search pipeline. It compares a TMPL_W x TMPL_H template, read from the search buffer, against a frame window at (iXstart, iYstart), read from SRAM.
- Generalises the fixed-size scorer: configurable template size, pixel width and memory read latency, plus a start/done handshake.
- Selects per run between similarity scoring and SAD (sum of absolute differences).
- Sits between the SRAM/search-buffer read ports and the best-match search controller.

Parameters:
- PIX_W, 10, pixel width in bits.
- COORD_W, 13, coordinate width in bits.
- TMPL_W, 32, template width in pixels (>=1).
- TMPL_H, 32, template height in pixels (>=1).
- RD_LAT, 2, cycles from address out to valid read data (>=1), identical for both memories.
- SCORE_W, 32, accumulator and score width.

Ports:
- iCLK  in  1  system clock (50 MHz).
- iRST_N  in  1  asynchronous active-low reset.
- iStart  in  1  single-cycle start request; sampled only in IDLE.
- iMode  in  1  0 = similarity, 1 = SAD; latched on accepted start.
- iXstart  in  COORD_W  window X origin; latched on accepted start.
- iYstart  in  COORD_W  window Y origin; latched on accepted start.
- reading_sram  in  PIX_W  SRAM pixel data, RD_LAT after its address.
- reading_search  in  PIX_W  search-buffer pixel data, RD_LAT after its address.
- oX_sram, oY_sram  out  COORD_W each  SRAM address = latched origin + internal X/Y.
- oX_search, oY_search  out  COORD_W each  template address = internal X/Y.
- oRdEn  out  1  high on cycles where addresses are valid.
- oBusy  out  1  high from accepted start until oDone.
- oDone  out  1  one-cycle pulse; oScore valid.
- oSat  out  1  accumulator saturated during the run; held with oScore.
- oScore  out  SCORE_W  final score; held until the next oDone.

Behaviour:
- Reset (asynchronous, iRST_N=0):
  - State is IDLE and every output is 0.
  - Address outputs are 0: internal counters and latched origin are 0.
  - Accumulator and the valid pipeline are cleared.
  - Reset mid-run aborts the run with no oDone.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - iStart=1 latches iXstart, iYstart and iMode, clears the accumulator, goes to ISSUE.
  - iStart outside IDLE is ignored, not queued.
- ISSUE:
  - Lasts N = TMPL_W*TMPL_H cycles, oRdEn=1.
  - Raster scan: X counts 0..TMPL_W-1; at TMPL_W-1, X wraps to 0 and Y increments.
  - After (TMPL_W-1, TMPL_H-1), go to DRAIN.
  - Exactly N addresses are issued; no off-by-one extra row or column.
- Valid tracking: an RD_LAT-deep shift register carries oRdEn, and its output qualifies the incoming data.
- Per-pixel term, on the qualified cycle:
  - d = |reading_sram - reading_search| at PIX_W bits unsigned, no wrap.
  - mode 0 term = (2^PIX_W - 1) - d.
  - mode 1 term = d.
- Accumulation:
  - Term is zero-extended to SCORE_W and added to the accumulator.
  - Saturates at 2^SCORE_W - 1 and sets the sticky saturation flag.
- DRAIN: waits until the valid pipeline is empty, then goes to DONE.
- DONE (one cycle):
  - oDone=1, and oScore and oSat are loaded with the final values.
  - oBusy drops in the same cycle; next state is IDLE.
  - oScore and oSat hold until the next DONE.
- Latency: with the start accepted at edge 0, oDone is high in cycle N+RD_LAT+1, after exactly one edge in DONE.
- Back-to-back: a start presented in the cycle after oDone (IDLE) is accepted. Minimum start-to-start spacing is N+RD_LAT+2 cycles.
- Origin addition wraps modulo 2^COORD_W; the frame bounds check belongs to the caller.
- iMode and the origin inputs may change freely while busy without effect.

Decomposition:
- Package corr_score_pkg holds:
  - the state encoding (IDLE, ISSUE, DRAIN, DONE);
  - the MODE_SIM and MODE_SAD constants;
  - the function pix_max(PIX_W).
- One sub-module, corr_term: a registered-free combinational abs-diff and mode select. It takes PIX_W and produces the per-pixel term.
- The address generator, valid pipeline, accumulator and FSM stay in the top module.

Test Plan:
- Test 1, identical pixels, mode 0. TMPL 4x4, RD_LAT=2, all pixels 500 -> oScore=16*1023=16368, oDone in cycle 19, oSat=0.
- Test 2, constant difference of 5, mode 1. SRAM=300, search=305 -> oScore=80. Mode 0 on the same data -> 16*1018=16288.
- Test 3, origin and scan order. Start (100, 7) -> address sequence (100,7)..(103,7),(100,8)..(103,10), exactly 16 oRdEn cycles, oX_search/oY_search 0..3.
- Test 4, iStart while busy. Pulse iStart at cycle 5 with origin (9,9) -> ignored; oDone once at cycle 19. A start at the cycle after oDone is accepted.
- Test 5, saturation. SCORE_W=12, mode 0, 4x4 template, equal pixels -> oScore=4095, oSat=1.
- Test 6, mid-run reset. Assert iRST_N=0 at cycle 8 -> all outputs 0 immediately, no oDone. A new start after release gives a correct full score.
